prince_sbox_cms_ctrl: RTL and testbench

Sequencer that time-shares one externally instantiated, pipelined 4-share CMS-masked PRINCE S-box over all 16 nibbles of a masked 64-bit state. The datapath is the per-bit share functions plus register stages. The controller captures the shared state, issues one nibble per randomness-backed cycle, and tracks pipeline occupancy. It writes results back by nibble index and returns the substituted shared state over a valid/ready handshake. It sits between the PRINCE round logic and the S-box layer.

---
 rtl/prince_cms_pkg.sv | 40 ++++
 rtl/prince_cms_occ_pipe.sv | 47 ++++
 rtl/prince_sbox_cms_ctrl.sv | 148 ++++++++++++++
 tb/tb_prince_sbox_cms_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/prince_cms_pkg.sv
// Shared definitions for the time-shared masked PRINCE S-box sequencer:
// share/nibble geometry, packed state types, FSM encoding and nibble accessors.
package prince_cms_pkg;

    localparam int NSHARES = 4;
    localparam int NNIB    = 16;
    localparam int IDX_W   = $clog2(NNIB);
    localparam int STATE_W = NSHARES * 64;
    localparam int NIB_W   = NSHARES * 4;

    // Share s, nibble k lives at bits [s*64 + 4k +: 4].
    typedef logic [STATE_W-1:0] state_t;
    // One nibble of every share: share s at bits [4s +: 4].
    typedef logic [NIB_W-1:0]   nib_t;
    typedef logic [IDX_W-1:0]   idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fsm_e;

    function automatic logic [3:0] get_nib(state_t st, int unsigned share, idx_t idx);
        int unsigned base;
        base = share * 64 + 4 * 32'(idx);
        return st[base +: 4];
    endfunction

    function automatic state_t set_nib(state_t st, int unsigned share, idx_t idx,
                                       logic [3:0] val);
        state_t      res;
        int unsigned base;
        res = st;
        base = share * 64 + 4 * 32'(idx);
        res[base +: 4] = val;
        return res;
    endfunction

endpackage

// File: rtl/prince_cms_occ_pipe.sv
// Occupancy tracker mirroring the S-box pipeline: one valid bit per stage,
// advancing only when the S-box pipeline itself advances.
module prince_cms_occ_pipe #(
    parameter int PIPE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic bit_in,
    output logic bit_out,
    output logic empty_next
);

    logic [PIPE-1:0] vld_q;
    logic [PIPE-1:0] vld_d;
    logic [PIPE-1:0] shift_val;

    // Shifted view of the valid vector: stage 0 takes the new bit.
    for (genvar gi = 0; gi < PIPE; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign shift_val[gi] = bit_in;
        end else begin : g_body
            assign shift_val[gi] = vld_q[gi-1];
        end
    end

    // Hold the vector unless the pipeline is enabled this cycle.
    always_comb begin
        vld_d = vld_q;
        if (en) begin
            vld_d = shift_val;
        end
    end

    // Valid bits clear on reset so stale S-box contents are never collected.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign bit_out    = vld_q[PIPE-1];
    assign empty_next = ~|vld_d;

endmodule

// File: rtl/prince_sbox_cms_ctrl.sv
// Sequencer feeding all 16 nibbles of a 4-share masked state through one
// external pipelined CMS S-box and reassembling the substituted state.
// Share lanes are never combined; each lane is routed independently.
module prince_sbox_cms_ctrl
    import prince_cms_pkg::*;
#(
    parameter int PIPE  = 2,
    parameter int RND_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [STATE_W-1:0]   state_in,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    output logic                 sbox_en,
    output logic [NIB_W-1:0]     sbox_din,
    input  logic [NIB_W-1:0]     sbox_dout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [STATE_W-1:0]   state_out
);

    // Randomness is consumed by the external S-box; the controller only
    // gates it, so the width matters solely as a sanity bound here.
    if (PIPE < 1 || RND_W < 1) begin : g_bad_param
        $error("prince_sbox_cms_ctrl: PIPE and RND_W must be at least 1");
    end

    fsm_e   fsm_q, fsm_d;
    idx_t   issue_idx_q, issue_idx_d;
    idx_t   collect_idx_q, collect_idx_d;
    state_t cap_q, cap_d;
    state_t state_out_q, state_out_d;
    logic   out_valid_q, out_valid_d;

    logic   busy;
    logic   occ_exit;
    logic   occ_empty_next;
    logic   collect_en;
    nib_t   issue_nib;

    // Pipeline advances only on cycles backed by fresh randomness.
    assign busy       = (fsm_q == ST_ISSUE) || (fsm_q == ST_DRAIN);
    assign sbox_en    = busy && rnd_valid;
    assign rnd_ready  = sbox_en;
    assign in_ready   = (fsm_q == ST_IDLE);
    assign collect_en = sbox_en && occ_exit;

    // Gather nibble issue_idx of each share of the captured state.
    for (genvar gi = 0; gi < NSHARES; gi++) begin : g_issue_lane
        assign issue_nib[gi*4 +: 4] = get_nib(cap_q, gi, issue_idx_q);
    end

    // Only real nibbles leave during ISSUE; DRAIN pushes zero bubbles.
    assign sbox_din = (fsm_q == ST_ISSUE) ? issue_nib : '0;

    prince_cms_occ_pipe #(
        .PIPE (PIPE)
    ) u_occ (
        .clk        (clk),
        .rst        (rst),
        .en         (sbox_en),
        .bit_in     (fsm_q == ST_ISSUE),
        .bit_out    (occ_exit),
        .empty_next (occ_empty_next)
    );

    // Next-state logic: capture, issue, drain, and write results back by index.
    always_comb begin
        fsm_d         = fsm_q;
        issue_idx_d   = issue_idx_q;
        collect_idx_d = collect_idx_q;
        cap_d         = cap_q;
        state_out_d   = state_out_q;
        out_valid_d   = out_valid_q;

        if (collect_en) begin
            for (int unsigned s = 0; s < NSHARES; s++) begin
                state_out_d = set_nib(state_out_d, s, collect_idx_q, sbox_dout[s*4 +: 4]);
            end
            // The FSM leaves DRAIN before a 17th collect, so saturating is enough.
            if (collect_idx_q != idx_t'(NNIB - 1)) begin
                collect_idx_d = collect_idx_q + idx_t'(1);
            end
        end

        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    cap_d         = state_in;
                    issue_idx_d   = '0;
                    collect_idx_d = '0;
                    fsm_d         = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (sbox_en) begin
                    if (issue_idx_q == idx_t'(NNIB - 1)) begin
                        fsm_d = ST_DRAIN;
                    end else begin
                        issue_idx_d = issue_idx_q + idx_t'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (sbox_en && occ_empty_next) begin
                    fsm_d       = ST_DONE;
                    out_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d       = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                fsm_d       = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q         <= ST_IDLE;
            issue_idx_q   <= '0;
            collect_idx_q <= '0;
            cap_q         <= '0;
            state_out_q   <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            issue_idx_q   <= issue_idx_d;
            collect_idx_q <= collect_idx_d;
            cap_q         <= cap_d;
            state_out_q   <= state_out_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign state_out = state_out_q;

endmodule

// File: tb/tb_prince_sbox_cms_ctrl.sv
// Directed bench: a behavioural PIPE-stage S-box (recombine, substitute,
// emit on share 0) sits behind the controller; results are hand-computed.
module tb_prince_sbox_cms_ctrl;
    import prince_cms_pkg::*;

    localparam int PIPE = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] state_in;
    logic               rnd_valid;
    logic               rnd_ready;
    logic               sbox_en;
    logic [NIB_W-1:0]   sbox_din;
    logic [NIB_W-1:0]   sbox_dout;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] state_out;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prince_sbox_cms_ctrl #(
        .PIPE  (PIPE),
        .RND_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .sbox_en   (sbox_en),
        .sbox_din  (sbox_din),
        .sbox_dout (sbox_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
    );

    // Behavioural S-box model
    function automatic logic [3:0] sbox4(logic [3:0] x);
        case (x)
            4'h0: return 4'hB;  4'h1: return 4'hF;  4'h2: return 4'h3;  4'h3: return 4'h2;
            4'h4: return 4'hA;  4'h5: return 4'hC;  4'h6: return 4'h9;  4'h7: return 4'h1;
            4'h8: return 4'h6;  4'h9: return 4'h7;  4'hA: return 4'h8;  4'hB: return 4'h0;
            4'hC: return 4'hE;  4'hD: return 4'h5;  4'hE: return 4'hD;  default: return 4'h4;
        endcase
    endfunction

    logic [NIB_W-1:0] model_pipe [PIPE];

    always @(posedge clk) begin
        if (sbox_en) begin
            model_pipe[0] <= {12'h000, sbox4(sbox_din[3:0] ^ sbox_din[7:4] ^
                                             sbox_din[11:8] ^ sbox_din[15:12])};
            for (int i = 1; i < PIPE; i++) begin
                model_pipe[i] <= model_pipe[i-1];
            end
        end
    end

    assign sbox_dout = model_pipe[PIPE-1];

    task automatic check(input string tag, input logic [STATE_W-1:0] got,
                         input logic [STATE_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one state and run until out_valid; returns in the first DONE cycle.
    task automatic run_job(input string tag, input logic [STATE_W-1:0] st,
                           input logic [63:0] stall_mask, input logic [NIB_W-1:0] exp_din0,
                           input logic [STATE_W-1:0] exp_out, input int exp_lat,
                           input int exp_pulses);
        int  waitc  = 0;
        int  pulses = 0;
        int  c;
        bit  done   = 0;
        while (!in_ready && waitc < 50) begin
            tick();
            waitc++;
        end
        check({tag, "_in_ready"}, STATE_W'(in_ready), STATE_W'(1));
        in_valid = 1'b1;
        state_in = st;
        tick();                       // handshake edge 0 behind us: cycle 1
        in_valid = 1'b0;
        state_in = '0;
        for (c = 1; c < 200; c++) begin
            rnd_valid = (c < 64) ? ~stall_mask[c] : 1'b1;
            #1;
            if (c == 1) check({tag, "_din0"}, STATE_W'(sbox_din), STATE_W'(exp_din0));
            if (rnd_ready) pulses++;
            if (out_valid) begin
                done = 1;
                break;
            end
            tick();
        end
        rnd_valid = 1'b1;
        check({tag, "_done"}, STATE_W'(done), STATE_W'(1));
        check({tag, "_latency"}, STATE_W'(c), STATE_W'(exp_lat));
        check({tag, "_rnd_pulses"}, STATE_W'(pulses), STATE_W'(exp_pulses));
        check({tag, "_state_out"}, state_out, exp_out);
        check({tag, "_in_ready_busy"}, STATE_W'(in_ready), STATE_W'(0));
        $display("job %s: latency %0d, rnd pulses %0d, out %0h", tag, c, pulses, state_out[63:0]);
    endtask

    // Accept the result and confirm the controller is back in IDLE.
    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_in_ready"}, STATE_W'(in_ready), STATE_W'(1));
        check({tag, "_idle_out_valid"}, STATE_W'(out_valid), STATE_W'(0));
    endtask

    localparam logic [STATE_W-1:0] ST_A  = {192'h0, 64'h0123456789ABCDEF};
    localparam logic [STATE_W-1:0] EXP_A = {192'h0, 64'hBF32AC916780E5D4};
    localparam logic [STATE_W-1:0] ST_B  = {128'h0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    localparam logic [STATE_W-1:0] EXP_B = {192'h0, 64'hBBBBBBBBBBBBBBBB};
    localparam logic [STATE_W-1:0] ST_C  = {64'h0, 64'h5555555555555555, 64'h3333333333333333, 64'h0};
    localparam logic [STATE_W-1:0] EXP_C = {192'h0, 64'h9999999999999999};
    localparam logic [STATE_W-1:0] ST_D  = {192'h0, 64'hFEDCBA9876543210};
    localparam logic [STATE_W-1:0] EXP_D = {192'h0, 64'h4D5E087619CA23FB};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rnd_valid = 1'b1;
        state_in  = '0;
        tick();
        tick();
        check("rst_in_ready",  STATE_W'(in_ready),  STATE_W'(1));
        check("rst_out_valid", STATE_W'(out_valid), STATE_W'(0));
        check("rst_sbox_en",   STATE_W'(sbox_en),   STATE_W'(0));
        check("rst_rnd_ready", STATE_W'(rnd_ready), STATE_W'(0));
        check("rst_state_out", state_out, '0);
        rst = 1'b0;
        tick();

        // Basic job, randomness always available
        run_job("ramp", ST_A, 64'h0, 16'h000F, EXP_A, 19, 18);
        release_out("ramp");

        // Two-share all-ones (recombined zero) with output backpressure
        run_job("ones", ST_B, 64'h0, 16'h00FF, EXP_B, 19, 18);
        in_valid = 1'b1;              // must be ignored outside IDLE
        state_in = ST_D;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_out_valid", STATE_W'(out_valid), STATE_W'(1));
            check("hold_state_out", state_out, EXP_B);
            check("hold_in_ready",  STATE_W'(in_ready),  STATE_W'(0));
        end
        in_valid = 1'b0;
        state_in = '0;
        release_out("ones");

        // Back-to-back job accepted straight out of IDLE
        run_job("b2b", ST_C, 64'h0, 16'h0530, EXP_C, 19, 18);
        release_out("b2b");

        // Randomness stalls in cycles 5-7 and 18
        run_job("stall", ST_A, 64'h0000_0000_0004_00E0, 16'h000F, EXP_A, 23, 18);
        release_out("stall");

        // Abort mid-ISSUE
        in_valid = 1'b1;
        state_in = ST_A;
        tick();
        in_valid = 1'b0;
        state_in = '0;
        for (int c = 1; c < 10; c++) tick();
        rst = 1'b1;                   // asserted during cycle 10
        tick();
        rst = 1'b0;
        check("abort_in_ready",  STATE_W'(in_ready),  STATE_W'(1));
        check("abort_out_valid", STATE_W'(out_valid), STATE_W'(0));
        check("abort_sbox_en",   STATE_W'(sbox_en),   STATE_W'(0));
        check("abort_rnd_ready", STATE_W'(rnd_ready), STATE_W'(0));
        check("abort_state_out", state_out, '0);
        $display("abort: in_ready %0d out_valid %0d", in_ready, out_valid);

        run_job("post_abort", ST_D, 64'h0, 16'h0000, EXP_D, 19, 18);
        release_out("post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
